pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Sits directly downstream of the system PLL wrapper. It consumes the PLL `locked` flag and drives the PLL `rst` input. It also produces per-output-clock reset requests that are released in a fixed order only after lock has been stable. It runs on the free-running 50 MHz reference clock, so it keeps operating while the PLL outputs are absent or unstable.

Parameters:
NUM_CLK, 3, number of PLL output domains needing a reset request (index 0 = 10 MHz, 1 = 200 MHz, 2 = 64 MHz)
RST_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt
LOCK_TIMEOUT, 50000, refclk cycles to wait for lock before retrying (1 ms)
STABLE_CYCLES, 1000, consecutive synchronized-locked cycles required before release
SEQ_GAP, 8, refclk cycles between successive rst_req deassertions
CNT_W, 8, width of the saturating event counters

Ports:
refclk  input  1  50 MHz reference clock, same net that feeds the PLL
rst_n  input  1  asynchronous active-low reset
locked  input  1  PLL locked flag, asynchronous to refclk
sw_reset  input  1  synchronous one-cycle pulse requesting a full PLL re-initialisation
pll_rst  output  1  active-high reset to the PLL
rst_req  output  NUM_CLK  active-high reset requests; each destination domain resynchronizes its own bit
ready  output  1  high only in RUN
loss_cnt  output  CNT_W  saturating count of lock losses after release began
timeout_cnt  output  CNT_W  saturating count of lock-wait timeouts

Behaviour:
- Reset (rst_n=0, asynchronous): state=PLL_RST, pll_rst=1, rst_req=all 1, ready=0, loss_cnt=0, timeout_cnt=0, internal counters=0.
- Synchronization: locked passes through a 2-FF synchronizer to give locked_s. Fixed latency is 2 refclk cycles. FSM decisions use locked_s only.
- PLL_RST:
  - pll_rst=1, rst_req all 1.
  - After RST_CYCLES cycles in this state, go to WAIT_LOCK; pll_rst=0 from that cycle.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE and clear the stable counter.
  - If LOCK_TIMEOUT cycles elapse without lock, timeout_cnt++ (saturating) and go to PLL_RST.
- STABLE:
  - Count consecutive locked_s=1 cycles.
  - If locked_s=0, return to WAIT_LOCK with the timeout counter restarted. This is a glitch, not a loss; no counter increments.
  - When the count reaches STABLE_CYCLES, go to RELEASE.
- RELEASE:
  - rst_req[0] deasserts on the first RELEASE cycle.
  - rst_req[i] deasserts exactly SEQ_GAP cycles after rst_req[i-1].
  - The cycle after the last bit deasserts, go to RUN; ready=1 in RUN.
- RUN: hold rst_req all 0 and ready=1 until an event below.
- Lock loss (locked_s=0 in RELEASE or RUN):
  - Next cycle: rst_req all 1, ready=0, loss_cnt++ (saturating at 2^CNT_W-1), state=PLL_RST.
- sw_reset=1 in any state:
  - Next cycle: state=PLL_RST, RST_CYCLES counter restarted, rst_req all 1, ready=0.
  - No counter increments.
  - sw_reset has priority over a simultaneous lock loss or timeout; in that case neither counter increments.
- Counter saturation: counters stop at all-ones and never wrap.
- Output style: all outputs are registered, with no combinational path from inputs to outputs.
- Static parameter checks: NUM_CLK≥1, SEQ_GAP≥1, STABLE_CYCLES≥1.

Decomposition:
- Shared package pll_rst_pkg:
  - state enum {PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN}
  - function computing timer width as clog2(max(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES)+1)
- One sub-module, sync_2ff, a generic single-bit 2-flop synchronizer with async active-low reset to 0. It is used for locked and reused by destination domains for their rst_req bits.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=10, SEQ_GAP=3, NUM_CLK=3.
- Power-up, locked rises 5 cycles after pll_rst falls and stays high -> pll_rst high for exactly 4 cycles. rst_req[0] falls 2+10 cycles after locked rises; rst_req[1] falls 3 cycles later, then rst_req[2] 3 cycles after that. ready=1 one cycle later. Both counters stay 0.
- locked never rises -> pll_rst pulses 4 cycles high, then 20 low, repeating. timeout_cnt reads 1, 2, 3 after each expiry.
- 3-cycle locked dropout during STABLE -> returns to WAIT_LOCK and the full 10-cycle stable window restarts. loss_cnt=0 and timeout_cnt=0.
- locked drops in RUN -> next cycle after locked_s falls: rst_req=3'b111, ready=0, pll_rst=1, loss_cnt=1. Re-lock repeats the ordered release.
- sw_reset pulse in RUN coincident with the first locked_s=0 cycle -> PLL_RST entered, loss_cnt unchanged. 256 forced losses -> loss_cnt holds 255.
- rst_n asserted mid-RELEASE (rst_req=3'b100) -> outputs return to reset values immediately, without waiting for a refclk edge.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    // Width of the shared state timer: enough to hold the largest count.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer, async active-low reset to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset, waits for stable lock, then releases per-domain reset
// requests in index order. Runs on the free-running reference clock.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int unsigned NUM_CLK       = 3,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned SEQ_GAP       = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               locked,
    input  logic               sw_reset,
    output logic               pll_rst,
    output logic [NUM_CLK-1:0] rst_req,
    output logic               ready,
    output logic [CNT_W-1:0]   loss_cnt,
    output logic [CNT_W-1:0]   timeout_cnt
);

    localparam int unsigned TW = timer_width(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
    localparam int unsigned IW = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock counts as stable cycle 1,
    // so STABLE itself only needs STABLE_CYCLES-1 further locked cycles.
    localparam logic [TW-1:0] STABLE_LAST = TW'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
    localparam logic [TW-1:0] GAP_LAST    = TW'(SEQ_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_CLK - 1);

    if (NUM_CLK < 1 || SEQ_GAP < 1 || STABLE_CYCLES < 1 || RST_CYCLES < 1 ||
        LOCK_TIMEOUT < 1 || SEQ_GAP > (1 << TW)) begin : g_bad_params
        $error("pll_reset_sequencer: illegal parameter combination");
    end

    logic               w_locked_s;
    state_t             r_state,       w_state_nxt;
    logic [TW-1:0]      r_cnt,         w_cnt_nxt;
    logic [IW-1:0]      r_idx,         w_idx_nxt;
    logic               r_pll_rst,     w_pll_rst_nxt;
    logic [NUM_CLK-1:0] r_rst_req,     w_rst_req_nxt;
    logic               r_ready,       w_ready_nxt;
    logic [CNT_W-1:0]   r_loss_cnt,    w_loss_nxt;
    logic [CNT_W-1:0]   r_timeout_cnt, w_tmo_nxt;

    sync_2ff u_lock_sync (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (locked),
        .o_q     (w_locked_s)
    );

    // State, timers, counters and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PLL_RST;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_pll_rst     <= 1'b1;
            r_rst_req     <= '1;
            r_ready       <= 1'b0;
            r_loss_cnt    <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_pll_rst     <= w_pll_rst_nxt;
            r_rst_req     <= w_rst_req_nxt;
            r_ready       <= w_ready_nxt;
            r_loss_cnt    <= w_loss_nxt;
            r_timeout_cnt <= w_tmo_nxt;
        end
    end

    // Next-state, counter updates and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_loss_nxt    = r_loss_cnt;
        w_tmo_nxt     = r_timeout_cnt;
        w_rst_req_nxt = '1;

        case (r_state)
            PLL_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = '0;
                    if (r_timeout_cnt != '1) w_tmo_nxt = r_timeout_cnt + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!w_locked_s) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = '0;
                    if (r_loss_cnt != '1) w_loss_nxt = r_loss_cnt + 1'b1;
                end else if (r_idx == IDX_LAST) begin
                    w_state_nxt = RUN;
                end else if (r_cnt == GAP_LAST) begin
                    w_idx_nxt = r_idx + 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = '0;
                    if (r_loss_cnt != '1) w_loss_nxt = r_loss_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase

        // Software re-init overrides any lock-loss or timeout decision above.
        if (sw_reset) begin
            w_state_nxt = PLL_RST;
            w_cnt_nxt   = '0;
            w_loss_nxt  = r_loss_cnt;
            w_tmo_nxt   = r_timeout_cnt;
        end

        w_pll_rst_nxt = (w_state_nxt == PLL_RST);
        w_ready_nxt   = (w_state_nxt == RUN);
        if (w_state_nxt == RUN) begin
            w_rst_req_nxt = '0;
        end else if (w_state_nxt == RELEASE) begin
            for (int unsigned i = 0; i < NUM_CLK; i++) begin
                w_rst_req_nxt[i] = (i > 32'(w_idx_nxt));
            end
        end
    end

    assign pll_rst     = r_pll_rst;
    assign rst_req     = r_rst_req;
    assign ready       = r_ready;
    assign loss_cnt    = r_loss_cnt;
    assign timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: run-length vector table plus
// hand sequences for counter saturation and asynchronous reset.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       sw_reset;
    logic       pll_rst;
    logic [2:0] rst_req;
    logic       ready;
    logic [7:0] loss_cnt;
    logic [7:0] timeout_cnt;

    pll_reset_sequencer #(
        .NUM_CLK       (3),
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (10),
        .SEQ_GAP       (3),
        .CNT_W         (8)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .locked      (locked),
        .sw_reset    (sw_reset),
        .pll_rst     (pll_rst),
        .rst_req     (rst_req),
        .ready       (ready),
        .loss_cnt    (loss_cnt),
        .timeout_cnt (timeout_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic       pll;
        logic [2:0] req;
        logic       rdy;
        logic [7:0] loss;
        logic [7:0] to;
    } obs_t;

    // Hold lk/sw for n rising edges, then compare outputs at the next falling edge.
    typedef struct {
        string       tag;
        bit          rst;
        int unsigned n;
        bit          lk;
        bit          sw;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];
    obs_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic obs_t obs(logic p, logic [2:0] q, logic r, logic [7:0] l, logic [7:0] t);
        return obs_t'({p, q, r, l, t});
    endfunction

    function automatic obs_t actual();
        return obs_t'({pll_rst, rst_req, ready, loss_cnt, timeout_cnt});
    endfunction

    task automatic add(input string tag, input bit rst, input int unsigned n, input bit lk,
                       input bit sw, input logic p, input logic [2:0] q, input logic r,
                       input logic [7:0] l, input logic [7:0] t);
        vec_t v;
        v.tag = tag; v.rst = rst; v.n = n; v.lk = lk; v.sw = sw;
        v.exp = obs(p, q, r, l, t);
        vecs.push_back(v);
    endtask

    task automatic check(input string tag);
        obs_t e;
        obs_t a;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected entry queued", tag);
            return;
        end
        e = sb.pop_front();
        a = actual();
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got pll_rst=%b rst_req=%b ready=%b loss=%0d timeout=%0d, want pll_rst=%b rst_req=%b ready=%b loss=%0d timeout=%0d",
                     tag, a.pll, a.req, a.rdy, a.loss, a.to, e.pll, e.req, e.rdy, e.loss, e.to);
        end
    endtask

    task automatic step(input int unsigned n);
        if (n == 0) return;
        repeat (n) @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst_n = 1'b0; locked = 1'b0; sw_reset = 1'b0;
        sb.push_back(obs(1'b1, 3'b111, 1'b0, 8'd0, 8'd0));
        #1 check("in_reset");
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    function automatic bit cond(input int unsigned which);
        case (which)
            0:       return rst_req != 3'b111;
            1:       return pll_rst == 1'b1;
            default: return rst_req == 3'b100;
        endcase
    endfunction

    task automatic wait_for(input int unsigned which, input string tag, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (cond(which)) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: condition not reached within 100 cycles", tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vec_t v;
        bit chk;
        rst_n = 1'b0; locked = 1'b0; sw_reset = 1'b0;

        //  tag            rst n   lk sw  pll req     rdy loss   to
        // Power-up, lock, ordered release, lock loss in RUN, re-lock, sw_reset vs loss.
        add("pwr_rstval",   1, 0,  0, 0,  1, 3'b111, 0, 8'd0, 8'd0);
        add("pwr_e3",       0, 3,  0, 0,  1, 3'b111, 0, 8'd0, 8'd0);
        add("pwr_e4",       0, 1,  0, 0,  0, 3'b111, 0, 8'd0, 8'd0);
        add("pwr_e8",       0, 4,  0, 0,  0, 3'b111, 0, 8'd0, 8'd0);
        add("stab_e19",     0, 11, 1, 0,  0, 3'b111, 0, 8'd0, 8'd0);
        add("rel0_e20",     0, 1,  1, 0,  0, 3'b110, 0, 8'd0, 8'd0);
        add("rel0_e22",     0, 2,  1, 0,  0, 3'b110, 0, 8'd0, 8'd0);
        add("rel1_e23",     0, 1,  1, 0,  0, 3'b100, 0, 8'd0, 8'd0);
        add("rel1_e25",     0, 2,  1, 0,  0, 3'b100, 0, 8'd0, 8'd0);
        add("rel2_e26",     0, 1,  1, 0,  0, 3'b000, 0, 8'd0, 8'd0);
        add("run_e27",      0, 1,  1, 0,  0, 3'b000, 1, 8'd0, 8'd0);
        add("run_e37",      0, 10, 1, 0,  0, 3'b000, 1, 8'd0, 8'd0);
        add("drop_sync",    0, 2,  0, 0,  0, 3'b000, 1, 8'd0, 8'd0);
        add("loss_1",       0, 1,  0, 0,  1, 3'b111, 0, 8'd1, 8'd0);
        add("reset_e41",    0, 1,  1, 0,  1, 3'b111, 0, 8'd1, 8'd0);
        add("wait_e44",     0, 3,  1, 0,  0, 3'b111, 0, 8'd1, 8'd0);
        add("stab_e53",     0, 9,  1, 0,  0, 3'b111, 0, 8'd1, 8'd0);
        add("rerel0",       0, 1,  1, 0,  0, 3'b110, 0, 8'd1, 8'd0);
        add("rerel1",       0, 3,  1, 0,  0, 3'b100, 0, 8'd1, 8'd0);
        add("rerel2",       0, 3,  1, 0,  0, 3'b000, 0, 8'd1, 8'd0);
        add("rerun",        0, 1,  1, 0,  0, 3'b000, 1, 8'd1, 8'd0);
        add("drop2_sync",   0, 2,  0, 0,  0, 3'b000, 1, 8'd1, 8'd0);
        add("sw_vs_loss",   0, 1,  0, 1,  1, 3'b111, 0, 8'd1, 8'd0);
        add("sw_after1",    0, 1,  0, 0,  1, 3'b111, 0, 8'd1, 8'd0);
        add("sw_after3",    0, 2,  0, 0,  1, 3'b111, 0, 8'd1, 8'd0);
        add("sw_wait",      0, 1,  0, 0,  0, 3'b111, 0, 8'd1, 8'd0);
        // Lock never arrives: 4 high / 20 low, timeout count climbs.
        add("to_rstval",    1, 0,  0, 0,  1, 3'b111, 0, 8'd0, 8'd0);
        add("to_e4",        0, 4,  0, 0,  0, 3'b111, 0, 8'd0, 8'd0);
        add("to_e23",       0, 19, 0, 0,  0, 3'b111, 0, 8'd0, 8'd0);
        add("to_1",         0, 1,  0, 0,  1, 3'b111, 0, 8'd0, 8'd1);
        add("to_e27",       0, 3,  0, 0,  1, 3'b111, 0, 8'd0, 8'd1);
        add("to_e28",       0, 1,  0, 0,  0, 3'b111, 0, 8'd0, 8'd1);
        add("to_e47",       0, 19, 0, 0,  0, 3'b111, 0, 8'd0, 8'd1);
        add("to_2",         0, 1,  0, 0,  1, 3'b111, 0, 8'd0, 8'd2);
        add("to_e52",       0, 4,  0, 0,  0, 3'b111, 0, 8'd0, 8'd2);
        add("to_3",         0, 20, 0, 0,  1, 3'b111, 0, 8'd0, 8'd3);
        add("to_e73",       0, 1,  0, 0,  1, 3'b111, 0, 8'd0, 8'd3);
        add("sw_in_rst",    0, 1,  0, 1,  1, 3'b111, 0, 8'd0, 8'd3);
        add("rst_restart",  0, 2,  0, 0,  1, 3'b111, 0, 8'd0, 8'd3);
        add("rst_e77",      0, 1,  0, 0,  1, 3'b111, 0, 8'd0, 8'd3);
        add("rst_e78",      0, 1,  0, 0,  0, 3'b111, 0, 8'd0, 8'd3);
        // Three-cycle dropout during STABLE restarts the whole window.
        add("gl_rstval",    1, 0,  0, 0,  1, 3'b111, 0, 8'd0, 8'd0);
        add("gl_e8",        0, 8,  0, 0,  0, 3'b111, 0, 8'd0, 8'd0);
        add("gl_e12",       0, 4,  1, 0,  0, 3'b111, 0, 8'd0, 8'd0);
        add("gl_drop",      0, 3,  0, 0,  0, 3'b111, 0, 8'd0, 8'd0);
        add("gl_e26",       0, 11, 1, 0,  0, 3'b111, 0, 8'd0, 8'd0);
        add("gl_rel0",      0, 1,  1, 0,  0, 3'b110, 0, 8'd0, 8'd0);
        add("gl_rel1",      0, 3,  1, 0,  0, 3'b100, 0, 8'd0, 8'd0);
        add("gl_rel2",      0, 3,  1, 0,  0, 3'b000, 0, 8'd0, 8'd0);
        add("gl_run",       0, 1,  1, 0,  0, 3'b000, 1, 8'd0, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) do_reset();
            locked   = v.lk;
            sw_reset = v.sw;
            sb.push_back(v.exp);
            step(v.n);
            check(v.tag);
        end
        sw_reset = 1'b0;

        // 256 forced losses during RELEASE: loss_cnt must stop at 255.
        do_reset();
        locked = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            wait_for(0, "reach_release", ok);
            if (!ok) break;
            locked = 1'b0;
            chk = (k == 1 || k == 2 || k == 255 || k == 256);
            if (chk) sb.push_back(obs(1'b1, 3'b111, 1'b0, (k > 255) ? 8'd255 : 8'(k), 8'd0));
            wait_for(1, "reach_loss", ok);
            if (!ok) break;
            if (chk) check($sformatf("loss_sat_k%0d", k));
            locked = 1'b1;
        end

        // Asynchronous reset in the middle of RELEASE clears everything at once.
        wait_for(2, "reach_req100", ok);
        if (ok) begin
            sb.push_back(obs(1'b0, 3'b100, 1'b0, 8'd255, 8'd0));
            check("pre_async_rst");
            sb.push_back(obs(1'b1, 3'b111, 1'b0, 8'd0, 8'd0));
            rst_n = 1'b0;
            #1 check("async_rst_mid_release");
            @(negedge refclk);
            rst_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
